// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, field positions, write masks and
// the exception codes already used by the exception controller.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_IM0 = 8;
  localparam int STATUS_IM7 = 15;
  localparam int STATUS_BEV = 22;

  localparam int CAUSE_EXC0 = 2;
  localparam int CAUSE_EXC4 = 6;
  localparam int CAUSE_IP0  = 8;
  localparam int CAUSE_IP1  = 9;
  localparam int CAUSE_IP2  = 10;
  localparam int CAUSE_IP7  = 15;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_BD   = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Cause register image as seen by MFC0.
  function automatic logic [31:0] cause_image(input logic       bd,
                                              input logic       ti,
                                              input logic [5:0] ip_hw,
                                              input logic [1:0] ip_sw,
                                              input logic [4:0] exc_code);
    return {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// MFC0/MTC0 access bus between the write-back stage (master) and CP0 (slave).
interface cp0_regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;

  modport master (output we, output waddr, output wdata, output raddr, input rdata);
  modport slave  (input we, input waddr, input wdata, input raddr, output rdata);
endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: prescaler, Count, Compare and the sticky timer interrupt.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] pre_q;
  logic          wrap;

  assign wrap = (pre_q == PW'(COUNT_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      // A software write to Count overrides the increment and restarts the prescaler.
      if (count_we) begin
        count <= wdata;
        pre_q <= '0;
      end else begin
        pre_q <= wrap ? '0 : pre_q + 1'b1;
        if (wrap) count <= count + 32'd1;
      end

      if (compare_we) compare <= wdata;

      // Clearing via Compare write wins over a coincident match.
      if (compare_we)                      ti <= 1'b0;
      else if (wrap && (count == compare)) ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 state: BadVAddr, Count, Compare, Status, Cause, EPC plus the
// interrupt enable/pending view consumed by the exception controller.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic               clk,
  input  logic               rst,
  cp0_regfile_if.slave       bus,
  input  logic               is_exception,
  input  logic [4:0]         excep_code,
  input  logic [31:0]        excep_pc,
  input  logic               is_bd,
  input  logic               we_badvaddr,
  input  logic [31:0]        badvaddr,
  input  logic               is_eret,
  input  logic [5:0]         hardware_int,
  output logic               is_ie,
  output logic               is_exl,
  output logic [7:0]         int_mask,
  output logic [1:0]         soft_int,
  output logic [5:0]         hw_int_pend,
  output logic [31:0]        epc,
  output logic [31:0]        exc_target,
  output logic               timer_int
);

  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        cause_bd_q;
  logic [4:0]  cause_exc_q;
  logic [1:0]  cause_ip_sw_q;
  logic [5:0]  hw_ip_p1;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        sw_wr;
  logic [31:0] rdata_c;

  // Writes from a flushed instruction (exception/ERET the same cycle) are dropped.
  assign sw_wr = bus.we & ~is_exception & ~is_eret;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (sw_wr && (bus.waddr == CP0_COUNT)),
    .compare_we (sw_wr && (bus.waddr == CP0_COMPARE)),
    .wdata      (bus.wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q      <= STATUS_RESET;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      cause_bd_q    <= 1'b0;
      cause_exc_q   <= '0;
      cause_ip_sw_q <= '0;
      hw_ip_p1      <= '0;
    end else begin
      // p0 -> p1: hardware interrupt lines sampled, IP7 shared with the timer
      hw_ip_p1 <= {hardware_int[5] | ti, hardware_int[4:0]};

      if (is_exception) begin
        cause_exc_q <= excep_code;
        if (!status_q[STATUS_EXL]) begin
          epc_q      <= excep_pc;
          cause_bd_q <= is_bd;
        end
        status_q[STATUS_EXL] <= 1'b1;
        if (we_badvaddr) badvaddr_q <= badvaddr;
      end else if (is_eret) begin
        status_q[STATUS_EXL] <= 1'b0;
      end else if (bus.we) begin
        case (bus.waddr)
          CP0_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
          CP0_CAUSE:  cause_ip_sw_q <= bus.wdata[CAUSE_IP1:CAUSE_IP0];
          CP0_EPC:    epc_q <= bus.wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    case (bus.raddr)
      CP0_BADVADDR: rdata_c = badvaddr_q;
      CP0_COUNT:    rdata_c = count;
      CP0_COMPARE:  rdata_c = compare;
      CP0_STATUS:   rdata_c = status_q;
      CP0_CAUSE:    rdata_c = cause_image(cause_bd_q, ti, hw_ip_p1, cause_ip_sw_q, cause_exc_q);
      CP0_EPC:      rdata_c = epc_q;
      default:      rdata_c = '0;
    endcase
  end

  assign bus.rdata   = rdata_c;
  assign is_ie       = status_q[STATUS_IE];
  assign is_exl      = status_q[STATUS_EXL];
  assign int_mask    = status_q[STATUS_IM7:STATUS_IM0];
  assign soft_int    = cause_ip_sw_q;
  assign hw_int_pend = hw_ip_p1;
  assign epc         = epc_q;
  assign exc_target  = EXC_VECTOR;
  assign timer_int   = ti;

endmodule
